// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern engine: pattern modes, FSM states
// and the per-mode initial pattern.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_ALT   = 2'd0,
      MODE_CHASE = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_OFF   = 2'd3
   } mode_e;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   // Widest LED bank init_pattern can describe; callers slice the low n bits.
   localparam int unsigned LED_MAX = 256;

   function automatic logic [LED_MAX-1:0] init_pattern(input mode_e mode, input int unsigned n);
      logic [LED_MAX-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < LED_MAX; i++) begin
         if (i < n) begin
            if (mode == MODE_ALT)        p[i] = i[0];
            else if (mode == MODE_CHASE) p[i] = (i == 0);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Programmable prescaler: holds the step interval and counts enabled cycles,
// flagging the terminal cycle on tick_o (combinational, registered by the caller).
module led_tick_gen
   import led_pkg::*;
#(
   parameter int unsigned CNT_W            = 32,
   parameter int unsigned DEFAULT_INTERVAL = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             cfg_load_i,
   input  logic [CNT_W-1:0] cfg_interval_i,
   output logic             tick_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] interval_q, interval_d;
   logic [CNT_W-1:0] last;

   // An interval of 0 behaves as 1, so the terminal count never underflows.
   always_comb last = (interval_q == '0) ? '0 : interval_q - 1'b1;

   // >= rather than == so a shrunk interval terminates at once instead of wrapping.
   assign tick_o = en_i && (cnt_q >= last);

   always_comb begin
      cnt_d      = cnt_q;
      interval_d = interval_q;
      if (clr_i)       cnt_d = '0;
      else if (en_i)   cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      if (cfg_load_i)  interval_d = cfg_interval_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         interval_q <= CNT_W'(DEFAULT_INTERVAL);
      end else begin
         cnt_q      <= cnt_d;
         interval_q <= interval_d;
      end
   end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescaled step tick drives alternate/chase/blink/off patterns.
// Optional brightness gating is built when LED_PWM_EN is defined.
module led_pattern_engine
   import led_pkg::*;
#(
   parameter int unsigned NUM_LEDS         = 18,
   parameter int unsigned CNT_W            = 32,
   parameter int unsigned DEFAULT_INTERVAL = 50_000_000,
   parameter int unsigned PWM_W            = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic                dir,
   input  logic                cfg_load,
   input  logic [CNT_W-1:0]    cfg_interval,
   input  logic [PWM_W-1:0]    duty,
   output logic [NUM_LEDS-1:0] led,
   output logic                tick
);

   state_e              state_q, state_d;
   mode_e               mode_q, mode_d;
   mode_e               mode_in;
   logic [NUM_LEDS-1:0] pat_q, pat_d, adv;
   logic [LED_MAX-1:0]  init_full;
   logic                tick_q, tick_d;
   logic                run_en, step;

   assign mode_in = mode_e'(mode);
   // A pending mode change blocks counting so it wins over a coincident terminal count.
   assign run_en  = (state_q == ST_RUN) && en && (mode_in == mode_q);

   led_tick_gen #(
      .CNT_W            (CNT_W),
      .DEFAULT_INTERVAL (DEFAULT_INTERVAL)
   ) u_tick_gen (
      .clk            (clk),
      .rst            (rst),
      .en_i           (run_en),
      .clr_i          (state_q == ST_INIT),
      .cfg_load_i     (cfg_load),
      .cfg_interval_i (cfg_interval),
      .tick_o         (step)
   );

   always_comb begin
      adv = '0;
      unique case (mode_q)
         MODE_ALT, MODE_BLINK: adv = ~pat_q;
         MODE_CHASE: begin
            for (int unsigned i = 0; i < NUM_LEDS; i++)
               adv[i] = dir ? pat_q[(i + 1) % NUM_LEDS] : pat_q[(i + NUM_LEDS - 1) % NUM_LEDS];
         end
         default: adv = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      pat_d     = pat_q;
      tick_d    = 1'b0;
      init_full = '0;
      unique case (state_q)
         ST_INIT: begin
            init_full = init_pattern(mode_in, NUM_LEDS);
            pat_d     = init_full[NUM_LEDS-1:0];
            mode_d    = mode_in;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (mode_in != mode_q) begin
               state_d = ST_INIT;
            end else if (step) begin
               tick_d = 1'b1;
               pat_d  = adv;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         mode_q  <= MODE_ALT;
         pat_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pat_q   <= pat_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

`ifdef LED_PWM_EN
   logic [PWM_W-1:0]    pwm_cnt_q;
   logic [NUM_LEDS-1:0] led_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         led_q     <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         led_q     <= pat_q & {NUM_LEDS{pwm_cnt_q < duty}};
      end
   end

   assign led = led_q;
`else
   logic unused_duty;
   assign unused_duty = ^duty;
   assign led         = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine (default build, no PWM gating).
module tb_led_pattern_engine;

   localparam int unsigned N   = 8;
   localparam int unsigned CW  = 16;
   localparam int unsigned DEF = 5;

   typedef struct packed {
      logic         tick;
      logic [N-1:0] led;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic [1:0]    mode = 2'd0;
   logic          dir = 1'b0;
   logic          cfg_load = 1'b0;
   logic [CW-1:0] cfg_interval = '0;
   logic [7:0]    duty = '0;
   logic [N-1:0]  led;
   logic          tick;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Reference model state: step parity, chase position, enabled cycles since last step.
   bit          m_init = 1'b1;
   bit          m_started = 1'b0;
   int          m_mode = 0;
   int unsigned m_interval = DEF;
   int unsigned m_elapsed = 0;
   bit          m_par = 1'b0;
   int          m_pos = 0;
   bit          m_tick = 1'b0;

   led_pattern_engine #(
      .NUM_LEDS         (N),
      .CNT_W            (CW),
      .DEFAULT_INTERVAL (DEF),
      .PWM_W            (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mode         (mode),
      .dir          (dir),
      .cfg_load     (cfg_load),
      .cfg_interval (cfg_interval),
      .duty         (duty),
      .led          (led),
      .tick         (tick)
   );

   always #5 clk = ~clk;

   function automatic int unsigned eff_of(input int unsigned iv);
      return (iv == 0) ? 1 : iv;
   endfunction

   function automatic logic [N-1:0] model_led();
      logic [N-1:0] v;
      v = '0;
      if (m_started) begin
         case (m_mode)
            0: for (int i = 0; i < N; i++) v[i] = ((i % 2) == 1) ^ m_par;
            1: v[m_pos] = 1'b1;
            2: v = m_par ? '1 : '0;
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   always @(posedge clk) begin
      exp_t        e;
      int unsigned nxt_int;
      if (rst) begin
         m_init = 1'b1; m_started = 1'b0; m_mode = 0; m_interval = DEF;
         m_elapsed = 0; m_par = 1'b0; m_pos = 0; m_tick = 1'b0;
      end else begin
         nxt_int = cfg_load ? int'(cfg_interval) : m_interval;
         m_tick  = 1'b0;
         if (m_init) begin
            m_mode = int'(mode); m_elapsed = 0; m_par = 1'b0; m_pos = 0;
            m_init = 1'b0; m_started = 1'b1;
         end else if (int'(mode) != m_mode) begin
            m_init = 1'b1;
         end else if (en) begin
            m_elapsed++;
            if (m_elapsed >= eff_of(m_interval)) begin
               m_elapsed = 0;
               m_tick    = 1'b1;
               m_par     = ~m_par;
               m_pos     = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
            end
         end
         m_interval = nxt_int;
      end
      e.tick = m_tick;
      e.led  = model_led();
      sb.push_back(e);
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            if (tick !== e.tick) begin
               bad++;
               $display("FAIL tick cyc=%0d got=%b want=%b", cyc, tick, e.tick);
            end
            total++;
            if (led !== e.led) begin
               bad++;
               $display("FAIL led cyc=%0d got=%h want=%h", cyc, led, e.led);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input int unsigned iv);
      cfg_load     = 1'b1;
      cfg_interval = CW'(iv);
      cycles(1);
      cfg_load     = 1'b0;
   endtask

   initial begin
      bit found;
      cycles(3);
      rst = 1'b0;
      cycles(14);
      load(4);
      cycles(20);

      mode = 2'd1;
      load(3);
      cycles(30);
      dir = 1'b1;
      cycles(15);

      mode = 2'd0;
      dir  = 1'b0;
      load(4);
      cycles(10);
      en = 1'b0;
      cycles(10);
      en = 1'b1;
      cycles(10);

      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         if (!m_init && m_mode == 0 && m_elapsed + 1 >= eff_of(m_interval)) found = 1'b1;
         else cycles(1);
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL terminal_wait got=timeout want=terminal");
      end
      mode = 2'd1;
      cycles(12);

      load(20);
      cycles(12);
      load(5);
      cycles(15);
      load(0);
      cycles(8);

      for (int k = 0; k < 3000; k++) begin
         en           = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) dir = 1'($urandom_range(0, 1));
         cfg_load     = ($urandom_range(0, 39) == 0);
         cfg_interval = CW'($urandom_range(0, 7));
         rst          = ($urandom_range(0, 299) == 0);
         cycles(1);
      end
      rst      = 1'b0;
      cfg_load = 1'b0;
      cycles(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
